// File: rtl/ucb_arm_select_if.sv
// ucb_arm_select_if: Q-value strobes in (Q1_t/Q2_t with float_Qx_valid), arm_sel/arm_valid out with arm_ready back
interface ucb_arm_select_if;
  logic [31:0] Q1_t;
  logic        float_Q1_valid;
  logic [31:0] Q2_t;
  logic        float_Q2_valid;
  logic        arm_ready;
  logic        arm_sel;
  logic        arm_valid;
  modport slave (
    input  Q1_t, float_Q1_valid, Q2_t, float_Q2_valid, arm_ready,
    output arm_sel, arm_valid
  );
  modport master (
    output Q1_t, float_Q1_valid, Q2_t, float_Q2_valid, arm_ready,
    input  arm_sel, arm_valid
  );
endinterface

// File: rtl/ucb_arm_select.sv
// ucb_arm_select: picks the arm with the larger float Q (NaN loses, ties alternate) and offers it on arm_valid/arm_ready; ports clk, s_aresetn (sync active-high), bus (Q strobes in, arm out), saturating pull_cnt1/pull_cnt2/round_cnt, sticky drop_err
module ucb_arm_select #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             s_aresetn,
  ucb_arm_select_if.slave  bus,
  output logic [CNT_W-1:0] pull_cnt1,
  output logic [CNT_W-1:0] pull_cnt2,
  output logic [CNT_W-1:0] round_cnt,
  output logic             drop_err
);
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;
  logic [1:0]  state;
  logic        got1, got2, tie, sel, vld;
  logic [31:0] q1, q2, k1, k2;
  logic        nan1, nan2, is_tie, win2;
  // Monotone unsigned key: -0 folded onto +0 so they compare equal
  function automatic logic [31:0] key(input logic [31:0] x);
    logic [31:0] c;
    c = (x == 32'h8000_0000) ? 32'h0 : x;
    return c[31] ? ~c : c | 32'h8000_0000;
  endfunction
  always_comb begin
    k1     = key(q1);
    k2     = key(q2);
    nan1   = &q1[30:23] & |q1[22:0];
    nan2   = &q2[30:23] & |q2[22:0];
    is_tie = (nan1 & nan2) | (!nan1 & !nan2 & (k1 == k2));
    win2   = nan1 ? 1'b1 : nan2 ? 1'b0 : (k2 > k1);
  end
  assign bus.arm_sel   = sel;
  assign bus.arm_valid = vld;
  always_ff @(posedge clk) begin
    if (s_aresetn) begin
      state     <= COLLECT;
      got1      <= 1'b0;
      got2      <= 1'b0;
      tie       <= 1'b0;
      sel       <= 1'b0;
      vld       <= 1'b0;
      q1        <= '0;
      q2        <= '0;
      pull_cnt1 <= '0;
      pull_cnt2 <= '0;
      round_cnt <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (state != COLLECT && (bus.float_Q1_valid || bus.float_Q2_valid)) drop_err <= 1'b1;
      case (state)
        COLLECT: begin
          if (bus.float_Q1_valid) begin
            q1   <= bus.Q1_t;
            got1 <= 1'b1;
          end
          if (bus.float_Q2_valid) begin
            q2   <= bus.Q2_t;
            got2 <= 1'b1;
          end
          if ((got1 || bus.float_Q1_valid) && (got2 || bus.float_Q2_valid)) state <= COMPARE;
        end
        COMPARE: begin
          sel   <= is_tie ? tie : win2;
          tie   <= tie ^ is_tie;
          vld   <= 1'b1;
          state <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.arm_ready) begin
            pull_cnt1 <= pull_cnt1 + CNT_W'(!sel && pull_cnt1 != '1);
            pull_cnt2 <= pull_cnt2 + CNT_W'(sel && pull_cnt2 != '1);
            round_cnt <= round_cnt + CNT_W'(round_cnt != '1);
            got1      <= 1'b0;
            got2      <= 1'b0;
            vld       <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule
